// File: rtl/if_id_skid_buffer.sv
// if_id_skid_buffer
//   Two-entry IF/ID buffer between instruction fetch and decode. The output
//   register (OUT) drives decode; the skid register (SKID) catches the one
//   fetch already in flight when decode stalls. Fetch is backpressured with a
//   registered ready, and a branch/jump flush discards everything held.
//
// Ports
//   fd_clk        clock, rising edge
//   fd_rst        asynchronous active-low reset
//   fd_i_instr    instruction from fetch
//   fd_i_pc       PC of that instruction
//   fd_i_ce       fetch output valid
//   fd_o_ready    buffer can accept next cycle (fetch gates its enable with it)
//   fd_i_stall    decode/hazard stall, OUT is not consumed
//   fd_i_flush    discard all entries (taken branch/jump)
//   fd_o_instr    instruction to decode
//   fd_o_pc       PC to decode
//   fd_o_ce       fd_o_instr/fd_o_pc valid
//   fd_o_count    entries held, 0..2
//   fd_o_overflow one-cycle pulse: fd_i_ce arrived while not ready, input dropped

module if_id_skid_buffer #(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                fd_clk,
  input  logic                fd_rst,
  input  logic [IWIDTH-1:0]   fd_i_instr,
  input  logic [PC_WIDTH-1:0] fd_i_pc,
  input  logic                fd_i_ce,
  output logic                fd_o_ready,
  input  logic                fd_i_stall,
  input  logic                fd_i_flush,
  output logic [IWIDTH-1:0]   fd_o_instr,
  output logic [PC_WIDTH-1:0] fd_o_pc,
  output logic                fd_o_ce,
  output logic [1:0]          fd_o_count,
  output logic                fd_o_overflow
);

  logic [IWIDTH-1:0]   r_out_instr;
  logic [PC_WIDTH-1:0] r_out_pc;
  logic                r_out_valid;
  logic [IWIDTH-1:0]   r_skid_instr;
  logic [PC_WIDTH-1:0] r_skid_pc;
  logic                r_skid_valid;
  logic                r_ready;
  logic                r_overflow;

  logic [IWIDTH-1:0]   w_out_instr_nxt;
  logic [PC_WIDTH-1:0] w_out_pc_nxt;
  logic                w_out_valid_nxt;
  logic [IWIDTH-1:0]   w_skid_instr_nxt;
  logic [PC_WIDTH-1:0] w_skid_pc_nxt;
  logic                w_skid_valid_nxt;
  logic                w_accept;
  logic                w_pop;

  assign w_accept = fd_i_ce & r_ready;
  assign w_pop    = r_out_valid & ~fd_i_stall;

  // OUT is always older than SKID, and SKID is only ever filled while OUT is
  // full, so "OUT empty" implies "SKID empty".
  always_comb begin
    w_out_instr_nxt  = r_out_instr;
    w_out_pc_nxt     = r_out_pc;
    w_out_valid_nxt  = r_out_valid;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_valid_nxt = r_skid_valid;

    if (fd_i_flush) begin
      // Present a NOP to decode and drop any fetch arriving this cycle.
      w_out_instr_nxt  = '0;
      w_out_pc_nxt     = '0;
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_out_valid) begin
      if (w_accept) begin
        w_out_instr_nxt = fd_i_instr;
        w_out_pc_nxt    = fd_i_pc;
        w_out_valid_nxt = 1'b1;
      end
    end else if (w_pop) begin
      if (r_skid_valid) begin
        // ready is low here, so no new fetch can compete with the skid entry
        w_out_instr_nxt  = r_skid_instr;
        w_out_pc_nxt     = r_skid_pc;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_out_instr_nxt = fd_i_instr;
        w_out_pc_nxt    = fd_i_pc;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_instr_nxt = fd_i_instr;
      w_skid_pc_nxt    = fd_i_pc;
      w_skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge fd_clk or negedge fd_rst) begin
    if (!fd_rst) begin
      r_out_instr  <= '0;
      r_out_pc     <= '0;
      r_out_valid  <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
      r_overflow   <= 1'b0;
    end else begin
      r_out_instr  <= w_out_instr_nxt;
      r_out_pc     <= w_out_pc_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      // Registered from the next SKID state so fetch sees it a cycle ahead.
      r_ready      <= ~w_skid_valid_nxt;
      r_overflow   <= fd_i_ce & ~r_ready & ~fd_i_flush;
    end
  end

  assign fd_o_instr    = r_out_instr;
  assign fd_o_pc       = r_out_pc;
  assign fd_o_ce       = r_out_valid;
  assign fd_o_ready    = r_ready;
  assign fd_o_count    = {1'b0, r_out_valid} + {1'b0, r_skid_valid};
  assign fd_o_overflow = r_overflow;

endmodule
